itcm_boot_loader: RTL and testbench
===================================

Name: itcm_boot_loader

Overview:
- AHB-Lite initiator that copies a boot image from flash into ITCM after reset or on request.
- Acts as the other end of the TCM AHB decoder: it drives read bursts on the system AHB toward flash.
- Writes returned words into the ITCM through a direct write port.
- Holds itcm_auto_load high for the whole copy, so the decoder blocks AHB ITCM accesses meanwhile.

Parameters:
- SRC_BASE, 32'h0010_0000, flash byte address of the image; word-aligned.
- DST_BASE, 32'h0000_0000, ITCM byte address of the first destination word; word-aligned.
- LOAD_WORDS, 1024, number of 32-bit words to copy; legal range 1..65535.
- AUTO_START, 1, 1 starts a load automatically in the first cycle after reset release.

Ports:
- HCLK  in  1  AHB clock.
- HRESETn  in  1  reset, asynchronous, active-low.
- load_start  in  1  single-cycle pulse that requests a load; honoured only in IDLE, DONE or ERR.
- HADDR  out  32  AHB address.
- HTRANS  out  2  IDLE=00, NONSEQ=10, SEQ=11.
- HWRITE  out  1  constant 0.
- HSIZE  out  3  constant 3'b010 (word).
- HBURST  out  3  constant 3'b001 (INCR).
- HWDATA  out  32  constant 0.
- HREADY  in  1  transfer-done from the interconnect.
- HRESP  in  2  00=OKAY, 01=ERROR.
- HRDATA  in  32  read data.
- itcm_auto_load  out  1  high while a copy is in progress.
- itcm_wr_en  out  1  one-cycle ITCM write strobe.
- itcm_wr_addr  out  32  ITCM byte address.
- itcm_wr_data  out  32  ITCM write data.
- load_done  out  1  sticky; set on successful completion.
- load_err  out  1  sticky; set on AHB error or checksum fail.

Behaviour:
- Reset values: HTRANS=IDLE, HADDR=0, itcm_auto_load=0, itcm_wr_en=0, itcm_wr_addr=0, itcm_wr_data=0, load_done=0, load_err=0. Reset mid-copy aborts the copy immediately; no done/err flag is produced for the aborted copy.
- FSM states: IDLE, ADDR, STREAM, DRAIN, DONE, ERR.
- IDLE: go to ADDR on load_start, or on the first cycle after reset when AUTO_START=1. On entry to ADDR: clear load_done/load_err, set itcm_auto_load=1, addr_cnt=0, data_cnt=0.
- ADDR: drive NONSEQ at HADDR=SRC_BASE. When HREADY=1, go to STREAM, or to DRAIN if LOAD_WORDS=1.
- STREAM: pipelined operation; the address phase of word n+1 overlaps the data phase of word n.
  - HTRANS=SEQ, except NONSEQ when the next address crosses a 1 KB boundary (HADDR[9:0]==0).
  - HREADY=0: hold HADDR/HTRANS and take no data.
  - HREADY=1 with HRESP=OKAY: capture HRDATA; advance addr and data counters.
  - After the last address is accepted, go to DRAIN.
- DRAIN: drive HTRANS=IDLE. Capture the final word on HREADY=1, then go to DONE.
- Write timing: each captured word produces itcm_wr_en=1 one cycle later.
  - itcm_wr_addr = DST_BASE + 4*data_cnt.
  - Writes are strictly in order, and exactly LOAD_WORDS strobes are issued.
- DONE: itcm_auto_load=0, load_done=1. Go to ADDR on load_start.
- Error response:
  - Trigger: HRESP=ERROR with HREADY=0 (first cycle of the two-cycle response), in any active state.
  - Next cycle: drive HTRANS=IDLE, then enter ERR.
  - ERR: no further writes, load_err=1, itcm_auto_load=0. Go to ADDR on load_start.
- load_start while busy: ignored.
- Counter widths: 17 bits, so LOAD_WORDS=65535 cannot wrap. HADDR arithmetic is modulo 2^32.

Optional Feature:
- Macro: ITCM_LOAD_CHECKSUM_EN.
- Enabled:
  - Keep a running 32-bit modulo-2^32 sum of the copied words.
  - Issue one extra read at SRC_BASE+4*LOAD_WORDS; this word is not written to ITCM.
  - Mismatch sets load_err=1 and leaves load_done=0; match sets load_done=1.
- Disabled: no extra read and no sum logic; load_done is set after the last write.

Decomposition:
- Shared package (krv_ahb_pkg): HTRANS/HSIZE/HBURST/HRESP encodings; the 1 KB boundary mask; the FSM state enum.
- One sub-module, itcm_load_wr_stage: registers captured data and address and generates itcm_wr_*.

Test Plan:
1. LOAD_WORDS=4, HREADY always 1, flash words A0..A3:
   - HTRANS sequence: NONSEQ, SEQ, SEQ, SEQ, IDLE.
   - 4 writes to 0x0, 0x4, 0x8, 0xC with A0..A3.
   - load_done=1 and itcm_auto_load falls after the 4th write.
2. Random HREADY stalls of 0–3 cycles:
   - HADDR held stable during each stall.
   - Same write data and order as the no-stall run.
3. SRC_BASE=0x0010_03F8, LOAD_WORDS=4:
   - NONSEQ issued at 0x0010_0400.
   - SEQ at the other addresses.
4. Two-cycle ERROR response on word 2:
   - HTRANS=IDLE in the second cycle.
   - Only words 0–1 written; load_err=1, load_done=0.
   - A later load_start restarts cleanly.
5. HRESETn asserted mid-STREAM:
   - All outputs take reset values asynchronously.
   - After release with AUTO_START=1, the full copy completes.
6. With ITCM_LOAD_CHECKSUM_EN:
   - Correct sum word gives load_done=1.
   - Corrupted sum word gives load_err=1.

Source files
------------

// File: rtl/krv_ahb_pkg.sv
// Shared AHB-Lite encodings and the boot-loader FSM state type.
package krv_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_INCR   = 3'b001;

  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;

  // Byte-offset bits inside a 1 KB region; zero means a fresh NONSEQ is needed.
  localparam logic [31:0] KB_BOUNDARY_MASK = 32'h0000_03FF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE,
    ST_ERR
  } load_state_e;

endpackage

// File: rtl/itcm_load_wr_stage.sv
// Registers each captured flash word and turns it into a one-cycle ITCM write.
module itcm_load_wr_stage #(
  parameter logic [31:0] DST_BASE = 32'h0000_0000
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        cap_valid,
  input  logic [16:0] cap_idx,
  input  logic [31:0] cap_data,
  output logic        itcm_wr_en,
  output logic [31:0] itcm_wr_addr,
  output logic [31:0] itcm_wr_data
);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      itcm_wr_en   <= 1'b0;
      itcm_wr_addr <= '0;
      itcm_wr_data <= '0;
    end else begin
      itcm_wr_en <= cap_valid;
      if (cap_valid) begin
        itcm_wr_addr <= DST_BASE + {13'd0, cap_idx, 2'b00};
        itcm_wr_data <= cap_data;
      end
    end
  end

endmodule

// File: rtl/itcm_boot_loader.sv
// AHB-Lite read-burst initiator copying a flash boot image into ITCM.
// Optional trailing checksum word check: define ITCM_LOAD_CHECKSUM_EN.
module itcm_boot_loader
  import krv_ahb_pkg::*;
#(
  parameter logic [31:0] SRC_BASE   = 32'h0010_0000,
  parameter logic [31:0] DST_BASE   = 32'h0000_0000,
  parameter int unsigned LOAD_WORDS = 1024,
  parameter bit          AUTO_START = 1'b1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        load_start,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic [1:0]  HRESP,
  input  logic [31:0] HRDATA,
  output logic        itcm_auto_load,
  output logic        itcm_wr_en,
  output logic [31:0] itcm_wr_addr,
  output logic [31:0] itcm_wr_data,
  output logic        load_done,
  output logic        load_err
);

`ifdef ITCM_LOAD_CHECKSUM_EN
  localparam logic [16:0] NREADS = 17'(LOAD_WORDS + 1);
  logic [31:0] sum_q;
`else
  localparam logic [16:0] NREADS = 17'(LOAD_WORDS);
`endif
  localparam logic [16:0] LAST_RD = NREADS - 17'd1;

  load_state_e state_q, state_d;
  logic [16:0] addr_cnt_q, addr_cnt_d;
  logic [16:0] data_cnt_q, data_cnt_d;
  logic        err_pend_q, err_pend_d;
  logic        first_q;
  logic        auto_load_q, done_q, err_q;
  logic        cap_valid, start_copy, beat_ok, go, active;
  logic [31:0] cur_addr;

  assign HWRITE         = 1'b0;
  assign HSIZE          = HSIZE_WORD;
  assign HBURST         = HBURST_INCR;
  assign HWDATA         = '0;
  assign itcm_auto_load = auto_load_q;
  assign load_done      = done_q;
  assign load_err       = err_q;
  assign cur_addr       = SRC_BASE + {13'd0, addr_cnt_q, 2'b00};

  always_comb begin
    state_d    = state_q;
    addr_cnt_d = addr_cnt_q;
    data_cnt_d = data_cnt_q;
    err_pend_d = 1'b0;
    cap_valid  = 1'b0;
    start_copy = 1'b0;
    HTRANS     = HTRANS_IDLE;
    HADDR      = '0;
    beat_ok    = HREADY && (HRESP == HRESP_OKAY) && !err_pend_q;
    go         = load_start || (AUTO_START && first_q);
    active     = (state_q == ST_ADDR) || (state_q == ST_STREAM) || (state_q == ST_DRAIN);

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (go) begin
          state_d    = ST_ADDR;
          start_copy = 1'b1;
          addr_cnt_d = '0;
          data_cnt_d = '0;
        end
      end
      ST_ADDR: begin
        HTRANS = HTRANS_NONSEQ;
        HADDR  = cur_addr;
        if (beat_ok) begin
          addr_cnt_d = addr_cnt_q + 17'd1;
          state_d    = (LAST_RD == '0) ? ST_DRAIN : ST_STREAM;
        end
      end
      ST_STREAM: begin
        HADDR  = cur_addr;
        HTRANS = ((cur_addr & KB_BOUNDARY_MASK) == '0) ? HTRANS_NONSEQ : HTRANS_SEQ;
        if (beat_ok) begin
          cap_valid  = 1'b1;
          data_cnt_d = data_cnt_q + 17'd1;
          addr_cnt_d = addr_cnt_q + 17'd1;
          if (addr_cnt_q == LAST_RD) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (beat_ok) begin
`ifdef ITCM_LOAD_CHECKSUM_EN
          // The final beat is the stored sum; it is compared, never written.
          state_d = (HRDATA == sum_q) ? ST_DONE : ST_ERR;
`else
          cap_valid  = 1'b1;
          data_cnt_d = data_cnt_q + 17'd1;
          state_d    = ST_DONE;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Second cycle of an ERROR response: cancel the pending transfer.
    if (err_pend_q) begin
      HTRANS  = HTRANS_IDLE;
      state_d = ST_ERR;
    end else if (active && (HRESP == HRESP_ERROR) && !HREADY) begin
      err_pend_d = 1'b1;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= ST_IDLE;
      addr_cnt_q  <= '0;
      data_cnt_q  <= '0;
      err_pend_q  <= 1'b0;
      first_q     <= 1'b1;
      auto_load_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_cnt_q <= addr_cnt_d;
      data_cnt_q <= data_cnt_d;
      err_pend_q <= err_pend_d;
      first_q    <= 1'b0;
      // Flags follow the state by one cycle so auto_load still covers the last write.
      if (start_copy) begin
        auto_load_q <= 1'b1;
        done_q      <= 1'b0;
        err_q       <= 1'b0;
      end else if (state_q == ST_DONE) begin
        auto_load_q <= 1'b0;
        done_q      <= 1'b1;
      end else if (state_q == ST_ERR) begin
        auto_load_q <= 1'b0;
        err_q       <= 1'b1;
      end
    end
  end

`ifdef ITCM_LOAD_CHECKSUM_EN
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)        sum_q <= '0;
    else if (start_copy) sum_q <= '0;
    else if (cap_valid)  sum_q <= sum_q + HRDATA;
  end
`endif

  itcm_load_wr_stage #(
    .DST_BASE(DST_BASE)
  ) u_wr_stage (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .cap_valid   (cap_valid),
    .cap_idx     (data_cnt_q),
    .cap_data    (HRDATA),
    .itcm_wr_en  (itcm_wr_en),
    .itcm_wr_addr(itcm_wr_addr),
    .itcm_wr_data(itcm_wr_data)
  );

endmodule

// File: tb/tb_itcm_boot_loader.sv
// Directed bench for itcm_boot_loader with a small AHB flash responder.
module tb_itcm_boot_loader;
  import krv_ahb_pkg::*;

  localparam logic [31:0] SRC = 32'h0010_0000;
`ifdef ITCM_LOAD_CHECKSUM_EN
  localparam int unsigned NBEATS = 5;
`else
  localparam int unsigned NBEATS = 4;
`endif

  logic        HCLK = 1'b0;
  logic        HRESETn, load_start;
  logic [31:0] haddr, hwdata, hrdata;
  logic [1:0]  htrans, hresp;
  logic        hwrite, hready;
  logic [2:0]  hsize, hburst;
  logic        auto_load, wr_en, done, err;
  logic [31:0] wr_addr, wr_data;

  logic [31:0] b_haddr, b_hwdata, b_wr_addr, b_wr_data;
  logic [1:0]  b_htrans;
  logic        b_hwrite, b_auto_load, b_wr_en, b_done, b_err;
  logic [2:0]  b_hsize, b_hburst;

  always #5 HCLK = ~HCLK;

  itcm_boot_loader #(
    .SRC_BASE(SRC), .DST_BASE(32'h0), .LOAD_WORDS(4), .AUTO_START(1'b1)
  ) u_dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .load_start(load_start),
    .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst),
    .HWDATA(hwdata), .HREADY(hready), .HRESP(hresp), .HRDATA(hrdata),
    .itcm_auto_load(auto_load), .itcm_wr_en(wr_en), .itcm_wr_addr(wr_addr),
    .itcm_wr_data(wr_data), .load_done(done), .load_err(err)
  );

  itcm_boot_loader #(
    .SRC_BASE(32'h0010_03F8), .DST_BASE(32'h0), .LOAD_WORDS(4), .AUTO_START(1'b1)
  ) u_bnd (
    .HCLK(HCLK), .HRESETn(HRESETn), .load_start(1'b0),
    .HADDR(b_haddr), .HTRANS(b_htrans), .HWRITE(b_hwrite), .HSIZE(b_hsize), .HBURST(b_hburst),
    .HWDATA(b_hwdata), .HREADY(1'b1), .HRESP(2'b00), .HRDATA(32'h0),
    .itcm_auto_load(b_auto_load), .itcm_wr_en(b_wr_en), .itcm_wr_addr(b_wr_addr),
    .itcm_wr_data(b_wr_data), .load_done(b_done), .load_err(b_err)
  );

  int unsigned total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Flash image: word at address a is A000_0000|a, except the stored checksum slot.
  logic [31:0] csum_word = 32'h8040_0018;
  function automatic logic [31:0] flash(input logic [31:0] a);
    return (a == SRC + 32'd16) ? csum_word : (32'hA000_0000 | a);
  endfunction

  function automatic logic [31:0] qv(input logic [31:0] q[$], input int unsigned k);
    return (k < q.size()) ? q[k] : 'x;
  endfunction

  // Previous-cycle bus snapshot, monitor queues and event counters.
  logic [1:0]  p_htrans = 2'b00, p_hresp = 2'b00;
  logic [31:0] p_haddr = '0;
  logic        p_hready = 1'b1;
  logic [31:0] wr_a[$], wr_d[$], acc_a[$], acc_t[$], b_a[$], b_t[$];
  logic        last_wr_auto = 1'b0;
  int unsigned stalls = 0, hold_viol = 0, err2_seen = 0, err2_bad = 0;

  always @(negedge HCLK) begin
    if (HRESETn) begin
      if (wr_en) begin
        wr_a.push_back(wr_addr);
        wr_d.push_back(wr_data);
        last_wr_auto = auto_load;
      end
      if (htrans != HTRANS_IDLE && hready) begin
        acc_a.push_back(haddr);
        acc_t.push_back({30'd0, htrans});
      end
      if (b_htrans != HTRANS_IDLE) begin
        b_a.push_back(b_haddr);
        b_t.push_back({30'd0, b_htrans});
      end
      if (!hready && hresp == HRESP_OKAY) stalls++;
      if (p_htrans != HTRANS_IDLE && !p_hready && p_hresp == HRESP_OKAY &&
          (haddr != p_haddr || htrans != p_htrans)) hold_viol++;
      if (hready && hresp == HRESP_ERROR) begin
        err2_seen++;
        if (htrans != HTRANS_IDLE) err2_bad++;
      end
    end
    p_htrans = htrans; p_haddr = haddr; p_hready = hready; p_hresp = hresp;
  end

  // Flash-side AHB responder with directed stall table and error injection.
  bit          stall_en = 1'b0, err_en = 1'b0;
  logic [31:0] err_addr = '0;
  int unsigned stall_tab [4] = '{1, 3, 0, 2};
  initial begin
    logic        dp;
    logic [31:0] dpa;
    int unsigned stall, eph, beat;
    dp = 1'b0; dpa = '0; stall = 0; eph = 0; beat = 0;
    hready = 1'b1; hresp = HRESP_OKAY; hrdata = '0;
    forever begin
      @(posedge HCLK); #1;
      if (!HRESETn) begin
        dp = 1'b0; stall = 0; eph = 0;
      end else if (p_hready) begin
        dp = p_htrans[1]; dpa = p_haddr; stall = 0; eph = 0;
        if (dp) begin
          if (stall_en) stall = stall_tab[beat % 4];
          if (err_en && dpa == err_addr) eph = 1;
          beat++;
        end
      end
      hresp = HRESP_OKAY; hrdata = '0;
      if (!dp) hready = 1'b1;
      else if (stall != 0) begin hready = 1'b0; stall--; end
      else if (eph == 1) begin hready = 1'b0; hresp = HRESP_ERROR; eph = 2; end
      else if (eph == 2) begin hready = 1'b1; hresp = HRESP_ERROR; eph = 0; end
      else begin hready = 1'b1; hrdata = flash(dpa); end
    end
  end

  task automatic pulse_start();
    @(negedge HCLK); load_start = 1'b1;
    @(negedge HCLK); load_start = 1'b0;
  endtask

  task automatic wait_flag(input bit want_err, input string tag);
    int unsigned n = 0;
    while (((want_err ? err : done) !== 1'b1) && n < 400) begin
      @(negedge HCLK); n++;
    end
    chk(tag, {31'd0, want_err ? err : done}, 32'd1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_htrans"}, {30'd0, htrans}, 32'd0);
    chk({tag, "_haddr"}, haddr, 32'd0);
    chk({tag, "_auto"}, {31'd0, auto_load}, 32'd0);
    chk({tag, "_wren"}, {31'd0, wr_en}, 32'd0);
    chk({tag, "_wraddr"}, wr_addr, 32'd0);
    chk({tag, "_wrdata"}, wr_data, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
  endtask

  task automatic chk_writes(input string tag, input int unsigned wb, input int unsigned n);
    logic [31:0] exp_d [4] = '{32'hA010_0000, 32'hA010_0004, 32'hA010_0008, 32'hA010_000C};
    logic [31:0] exp_a [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
    chk({tag, "_nwr"}, wr_d.size() - wb, n);
    for (int unsigned i = 0; i < n; i++) begin
      chk({tag, "_wraddr"}, qv(wr_a, wb + i), exp_a[i]);
      chk({tag, "_wrdata"}, qv(wr_d, wb + i), exp_d[i]);
    end
  endtask

  initial begin
    int unsigned wb, ab, st0, hv0, e0, eb0, n;
    logic [31:0] b_exp_a [4] = '{32'h0010_03F8, 32'h0010_03FC, 32'h0010_0400, 32'h0010_0404};
    logic [31:0] b_exp_t [4] = '{32'h2, 32'h3, 32'h2, 32'h3};

    HRESETn = 1'b0; load_start = 1'b0;
    repeat (3) @(negedge HCLK);
    chk_reset("rst");
    chk("hsize", {29'd0, hsize}, 32'h2);
    chk("hburst", {29'd0, hburst}, 32'h1);
    chk("hwrite", {31'd0, hwrite}, 32'd0);

    // 1: auto-start copy, no stalls
    wb = wr_d.size(); ab = acc_t.size();
    HRESETn = 1'b1;
    wait_flag(1'b0, "t1_done");
    chk("t1_beats", acc_t.size() - ab, NBEATS);
    for (int unsigned i = 0; i < 4; i++) begin
      chk("t1_htrans", qv(acc_t, ab + i), (i == 0) ? 32'h2 : 32'h3);
      chk("t1_haddr", qv(acc_a, ab + i), SRC + 32'(4 * i));
    end
    chk("t1_idle", {30'd0, htrans}, 32'd0);
    chk_writes("t1", wb, 4);
    chk("t1_auto_at_last_wr", {31'd0, last_wr_auto}, 32'd1);
    chk("t1_auto_low", {31'd0, auto_load}, 32'd0);
    chk("t1_err", {31'd0, err}, 32'd0);

    // 3: 1 KB boundary crossing on the second instance
    for (int unsigned i = 0; i < 4; i++) begin
      chk("t3_haddr", qv(b_a, i), b_exp_a[i]);
      chk("t3_htrans", qv(b_t, i), b_exp_t[i]);
    end

    // 2: stalled beats
    wb = wr_d.size(); st0 = stalls; hv0 = hold_viol;
    stall_en = 1'b1;
    pulse_start();
    wait_flag(1'b0, "t2_done");
    stall_en = 1'b0;
    chk_writes("t2", wb, 4);
    chk("t2_hold", hold_viol - hv0, 32'd0);
    chk("t2_stalled", {31'd0, stalls != st0}, 32'd1);

    // 4: ERROR response on word 2, then clean restart
    wb = wr_d.size(); e0 = err2_seen; eb0 = err2_bad;
    err_addr = SRC + 32'd8; err_en = 1'b1;
    pulse_start();
    wait_flag(1'b1, "t4_err");
    err_en = 1'b0;
    repeat (4) @(negedge HCLK);
    chk_writes("t4", wb, 2);
    chk("t4_done", {31'd0, done}, 32'd0);
    chk("t4_auto", {31'd0, auto_load}, 32'd0);
    chk("t4_err2_seen", err2_seen - e0, 32'd1);
    chk("t4_err2_idle", err2_bad - eb0, 32'd0);
    wb = wr_d.size();
    pulse_start();
    wait_flag(1'b0, "t4_restart_done");
    chk_writes("t4r", wb, 4);
    chk("t4r_err", {31'd0, err}, 32'd0);

    // 5: asynchronous reset mid-stream, then auto-restart
    wb = wr_d.size(); n = 0;
    pulse_start();
    while (wr_d.size() - wb < 2 && n < 200) begin @(negedge HCLK); n++; end
    chk("t5_reached", {31'd0, wr_d.size() - wb >= 2}, 32'd1);
    #2 HRESETn = 1'b0;
    #1 chk_reset("t5_rst");
    repeat (2) @(negedge HCLK);
    wb = wr_d.size();
    HRESETn = 1'b1;
    wait_flag(1'b0, "t5_done");
    chk_writes("t5", wb, 4);

`ifdef ITCM_LOAD_CHECKSUM_EN
    // 6: corrupted then correct checksum word
    wb = wr_d.size();
    csum_word = 32'hDEAD_BEEF;
    pulse_start();
    wait_flag(1'b1, "t6_bad_err");
    chk("t6_bad_done", {31'd0, done}, 32'd0);
    chk_writes("t6", wb, 4);
    csum_word = 32'h8040_0018;
    pulse_start();
    wait_flag(1'b0, "t6_good_done");
    chk("t6_good_err", {31'd0, err}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
